// File: rtl/bridge_pkg.sv
// bridge_pkg: shared types and constants for the APF bridge command blocks.
package bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        COMPLETE,
        RELEASE
    } rd_req_state_e;

    localparam logic [2:0] DS_ERR_TIMEOUT = 3'h7;

    typedef struct packed {
        logic [15:0] slot_id;
        logic [31:0] bridge_addr;
        logic [31:0] length;
        logic [31:0] offset;
    } dataslot_param_t;

endpackage

// File: rtl/timeout_counter.sv
// timeout_counter: saturating watchdog; expired flags the last allowed cycle, LIMIT 0 never expires.
module timeout_counter #(
    parameter logic [31:0] LIMIT     = 32'd74_250_000,
    parameter int          CNT_WIDTH = 27
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(LIMIT - 32'd1);

    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && cnt != LAST)
            cnt <= cnt + 1'b1;
    end

    assign expired = (LIMIT != 32'd0) && (cnt == LAST);

endmodule

// File: rtl/dataslot_read_requester.sv
// dataslot_read_requester: turns a held dataslot read request into the APF target_dataslot_read handshake.
module dataslot_read_requester
    import bridge_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd74_250_000,
    parameter int          CNT_WIDTH      = 27
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [15:0] req_slot_id,
    input  logic [31:0] req_bridge_addr,
    input  logic [31:0] req_length,
    input  logic [31:0] req_offset,
    output logic        req_done,
    output logic [2:0]  req_err,
    output logic        req_busy,
    output logic        target_dataslot_read,
    output logic [15:0] target_dataslot_id,
    output logic [31:0] target_dataslot_bridgeaddr,
    output logic [31:0] target_dataslot_length,
    output logic [31:0] target_dataslot_slotoffset,
    input  logic        target_dataslot_ack,
    input  logic        target_dataslot_done,
    input  logic [2:0]  target_dataslot_err
);

    rd_req_state_e   state;
    dataslot_param_t p;
    logic            expired;
    logic            wd_enable;
    logic            wd_clear;

    // Clearing on every exit edge means the next counted state starts from zero.
    always_comb begin
        wd_enable = (state == ISSUE) || (state == WAIT_DONE);
        wd_clear  = !wd_enable || target_dataslot_done
                    || (state == ISSUE && target_dataslot_ack) || expired;
        target_dataslot_read       = state == ISSUE;
        req_done                   = state == COMPLETE;
        req_busy                   = (state == ISSUE) || (state == WAIT_DONE) || (state == COMPLETE);
        target_dataslot_id         = p.slot_id;
        target_dataslot_bridgeaddr = p.bridge_addr;
        target_dataslot_length     = p.length;
        target_dataslot_slotoffset = p.offset;
    end

    timeout_counter #(
        .LIMIT    (TIMEOUT_CYCLES),
        .CNT_WIDTH(CNT_WIDTH)
    ) u_wd (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            p       <= '0;
            req_err <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    p     <= '{slot_id: req_slot_id, bridge_addr: req_bridge_addr,
                               length: req_length, offset: req_offset};
                    state <= ISSUE;
                end
                // done wins over ack so a combined ack+done completes directly
                ISSUE: if (target_dataslot_done) begin
                    req_err <= target_dataslot_err;
                    state   <= COMPLETE;
                end else if (target_dataslot_ack) begin
                    state <= WAIT_DONE;
                end else if (expired) begin
                    req_err <= DS_ERR_TIMEOUT;
                    state   <= COMPLETE;
                end
                WAIT_DONE: if (target_dataslot_done) begin
                    req_err <= target_dataslot_err;
                    state   <= COMPLETE;
                end else if (expired) begin
                    req_err <= DS_ERR_TIMEOUT;
                    state   <= COMPLETE;
                end
                COMPLETE: state <= RELEASE;
                RELEASE:  if (!req_valid) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dataslot_read_requester.sv
// tb_dataslot_read_requester: directed self-checking bench for the dataslot read requester.
module tb_dataslot_read_requester;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [15:0] req_slot_id = '0;
    logic [31:0] req_bridge_addr = '0;
    logic [31:0] req_length = '0;
    logic [31:0] req_offset = '0;
    logic        req_done;
    logic [2:0]  req_err;
    logic        req_busy;
    logic        target_dataslot_read;
    logic [15:0] target_dataslot_id;
    logic [31:0] target_dataslot_bridgeaddr;
    logic [31:0] target_dataslot_length;
    logic [31:0] target_dataslot_slotoffset;
    logic        target_dataslot_ack = 1'b0;
    logic        target_dataslot_done = 1'b0;
    logic [2:0]  target_dataslot_err = '0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dataslot_read_requester #(
        .TIMEOUT_CYCLES(32'd100),
        .CNT_WIDTH     (27)
    ) dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .req_valid                 (req_valid),
        .req_slot_id               (req_slot_id),
        .req_bridge_addr           (req_bridge_addr),
        .req_length                (req_length),
        .req_offset                (req_offset),
        .req_done                  (req_done),
        .req_err                   (req_err),
        .req_busy                  (req_busy),
        .target_dataslot_read      (target_dataslot_read),
        .target_dataslot_id        (target_dataslot_id),
        .target_dataslot_bridgeaddr(target_dataslot_bridgeaddr),
        .target_dataslot_length    (target_dataslot_length),
        .target_dataslot_slotoffset(target_dataslot_slotoffset),
        .target_dataslot_ack       (target_dataslot_ack),
        .target_dataslot_done      (target_dataslot_done),
        .target_dataslot_err       (target_dataslot_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [15:0] id, input logic [31:0] addr,
                           input logic [31:0] len, input logic [31:0] off);
        req_slot_id     = id;
        req_bridge_addr = addr;
        req_length      = len;
        req_offset      = off;
        req_valid       = 1'b1;
    endtask

    int rd_cycles;
    int done_pulses;

    initial begin
        // reset state
        #12;
        check("rst_read", target_dataslot_read, 0);
        check("rst_done", req_done, 0);
        check("rst_busy", req_busy, 0);
        check("rst_err", req_err, 0);
        check("rst_id", target_dataslot_id, 0);
        check("rst_addr", target_dataslot_bridgeaddr, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // nominal: ack after 3 cycles, done 20 cycles later
        request(16'd2, 32'h1000_1620, 32'h50, 32'h0);
        tick();
        check("nom_read_n1", target_dataslot_read, 1);
        check("nom_busy", req_busy, 1);
        check("nom_id", target_dataslot_id, 2);
        check("nom_addr", target_dataslot_bridgeaddr, 32'h1000_1620);
        check("nom_len", target_dataslot_length, 32'h50);
        tick();
        tick();
        check("nom_read_n3", target_dataslot_read, 1);
        target_dataslot_ack = 1'b1;
        tick();
        target_dataslot_ack = 1'b0;
        check("nom_read_drop", target_dataslot_read, 0);
        check("nom_busy_wait", req_busy, 1);
        request(16'd9, 32'hdead_beef, 32'h1, 32'h1);
        done_pulses = 0;
        for (int i = 0; i < 19; i++) begin
            if (req_done) done_pulses++;
            tick();
        end
        check("nom_no_early_done", done_pulses, 0);
        target_dataslot_done = 1'b1;
        target_dataslot_err  = 3'h0;
        tick();
        target_dataslot_done = 1'b0;
        check("nom_done", req_done, 1);
        check("nom_err", req_err, 0);
        check("nom_id_held", target_dataslot_id, 2);
        tick();
        check("nom_done_pulse", req_done, 0);
        check("nom_busy_rel", req_busy, 0);
        rd_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            if (target_dataslot_read) rd_cycles++;
            tick();
        end
        check("nom_no_reissue", rd_cycles, 0);

        // host error
        req_valid = 1'b0;
        tick();
        request(16'd3, 32'h2000_0000, 32'h10, 32'h0);
        tick();
        check("herr_read", target_dataslot_read, 1);
        target_dataslot_ack = 1'b1;
        tick();
        target_dataslot_ack  = 1'b0;
        target_dataslot_done = 1'b1;
        target_dataslot_err  = 3'h2;
        tick();
        target_dataslot_done = 1'b0;
        target_dataslot_err  = 3'h0;
        check("herr_done", req_done, 1);
        check("herr_err", req_err, 2);
        tick();
        check("herr_done_pulse", req_done, 0);
        check("herr_err_held", req_err, 2);

        // ack and done together in ISSUE
        req_valid = 1'b0;
        tick();
        request(16'd4, 32'h3000_0000, 32'h20, 32'h0);
        tick();
        check("ad_err_not_cleared", req_err, 2);
        target_dataslot_ack  = 1'b1;
        target_dataslot_done = 1'b1;
        target_dataslot_err  = 3'h1;
        tick();
        target_dataslot_ack  = 1'b0;
        target_dataslot_done = 1'b0;
        target_dataslot_err  = 3'h0;
        check("ad_done", req_done, 1);
        check("ad_err", req_err, 1);
        done_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (req_done) done_pulses++;
        end
        check("ad_single_complete", done_pulses, 0);

        // timeout: never ack
        req_valid = 1'b0;
        tick();
        request(16'd5, 32'h4000_0000, 32'h30, 32'h0);
        tick();
        rd_cycles = 0;
        for (int i = 0; i < 200; i++) begin
            if (!target_dataslot_read) break;
            rd_cycles++;
            tick();
        end
        check("to_read_cycles", rd_cycles, 100);
        check("to_done", req_done, 1);
        check("to_err", req_err, 7);
        target_dataslot_ack = 1'b1;
        tick();
        target_dataslot_ack = 1'b0;
        tick();
        check("to_late_ack_read", target_dataslot_read, 0);
        check("to_late_ack_busy", req_busy, 0);
        check("to_late_ack_done", req_done, 0);

        // back-to-back: held valid gives nothing, a 1-cycle gap gives a new command
        rd_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (target_dataslot_read) rd_cycles++;
        end
        check("b2b_held_no_read", rd_cycles, 0);
        req_valid = 1'b0;
        tick();
        request(16'd6, 32'h5000_0000, 32'h40, 32'h40);
        tick();
        check("b2b_read", target_dataslot_read, 1);
        check("b2b_offset", target_dataslot_slotoffset, 32'h40);
        check("b2b_id", target_dataslot_id, 6);

        // async reset in WAIT_DONE
        target_dataslot_ack = 1'b1;
        tick();
        target_dataslot_ack = 1'b0;
        check("rstm_busy_before", req_busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstm_busy", req_busy, 0);
        check("rstm_read", target_dataslot_read, 0);
        check("rstm_offset", target_dataslot_slotoffset, 0);
        check("rstm_err", req_err, 0);
        req_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("rstm_idle", req_busy, 0);
        request(16'd7, 32'h6000_0000, 32'h8, 32'h0);
        tick();
        check("fresh_read", target_dataslot_read, 1);
        check("fresh_id", target_dataslot_id, 7);

        // valid dropped mid-command still completes, then RELEASE exits at once
        req_valid = 1'b0;
        target_dataslot_ack = 1'b1;
        tick();
        target_dataslot_ack  = 1'b0;
        target_dataslot_done = 1'b1;
        target_dataslot_err  = 3'h3;
        tick();
        target_dataslot_done = 1'b0;
        target_dataslot_err  = 3'h0;
        check("drop_done", req_done, 1);
        check("drop_err", req_err, 3);
        tick();
        tick();
        request(16'd8, 32'h7000_0000, 32'h4, 32'h0);
        tick();
        check("drop_reaccept", target_dataslot_read, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
